fan_dac_loop: RTL and testbench

- Closed-loop fan drive stage that sits directly downstream of the temperature-to-RPM policy block.
- Consumes the target speed SPEED_RPM and the measured tach speed FAN_RPM.
- Each time a new measurement arrives, steps an 8-bit FAN_DAC toward the target.
- Owns spin-up, stall detection/recovery and a measurement watchdog; fails safe to full drive.

---
 rtl/fan_pkg.sv | 26 ++
 rtl/fan_dac_step.sv | 40 ++++
 rtl/fan_dac_loop.sv | 157 +++++++++++++++
 tb/tb_fan_dac_loop.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared definitions for the fan control path: state encoding,
// common RPM set points and default DAC limits.
package fan_pkg;

    typedef enum logic [1:0] {
        ST_SPINUP = 2'd0,
        ST_TRACK  = 2'd1,
        ST_STALL  = 2'd2
    } fan_state_e;

    localparam logic [15:0] RPM_3000 = 16'd3000;
    localparam logic [15:0] RPM_4000 = 16'd4000;
    localparam logic [15:0] RPM_5000 = 16'd5000;
    localparam logic [15:0] RPM_6000 = 16'd6000;

    localparam int unsigned DAC_MAX_DEF = 255;
    localparam int unsigned DAC_MIN_DEF = 40;

    function automatic logic [15:0] rpm_mag(
        input logic [15:0] a,
        input logic [15:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/fan_dac_step.sv
// Saturating DAC step toward the target: deadband hold, fast/slow
// step size, clamped to [DAC_MIN, DAC_MAX].
module fan_dac_step
    import fan_pkg::*;
#(
    parameter int unsigned DAC_MAX   = DAC_MAX_DEF,
    parameter int unsigned DAC_MIN   = DAC_MIN_DEF,
    parameter int unsigned DEADBAND  = 100,
    parameter int unsigned BIG_ERR   = 1000,
    parameter int unsigned STEP_FAST = 8,
    parameter int unsigned STEP_SLOW = 1
) (
    input  logic [7:0]  dac_i,
    input  logic        neg_i,
    input  logic [15:0] mag_i,
    output logic [7:0]  dac_o,
    output logic        hold_o
);

    logic [8:0] step;
    logic [8:0] up;
    logic [8:0] dn;

    always_comb begin
        hold_o = (mag_i <= 16'(DEADBAND));
        step   = (mag_i > 16'(BIG_ERR)) ? 9'(STEP_FAST) : 9'(STEP_SLOW);
        up     = {1'b0, dac_i} + step;
        // bit 8 of dn flags a borrow past zero
        dn     = {1'b0, dac_i} - step;
        dac_o  = dac_i;
        if (!hold_o) begin
            if (!neg_i) begin
                dac_o = (up > 9'(DAC_MAX)) ? 8'(DAC_MAX) : up[7:0];
            end else begin
                dac_o = (dn[8] || dn < 9'(DAC_MIN)) ? 8'(DAC_MIN) : dn[7:0];
            end
        end
    end

endmodule

// File: rtl/fan_dac_loop.sv
// Closed-loop fan drive: spin-up, RPM tracking, stall recovery and
// a measurement watchdog that falls back to full drive.
module fan_dac_loop
    import fan_pkg::*;
#(
    parameter int unsigned DAC_MAX       = DAC_MAX_DEF,
    parameter int unsigned DAC_MIN       = DAC_MIN_DEF,
    parameter int unsigned DEADBAND      = 100,
    parameter int unsigned BIG_ERR       = 1000,
    parameter int unsigned STEP_FAST     = 8,
    parameter int unsigned STEP_SLOW     = 1,
    parameter int unsigned SPINUP_CYC    = 400000,
    parameter int unsigned STALL_RPM     = 500,
    parameter int unsigned STALL_SAMPLES = 3,
    parameter int unsigned STALL_HOLD    = 800000,
    parameter int unsigned WD_CYC        = 1200000
) (
    input  logic        CLK_400K,
    input  logic        RESET,
    input  logic [15:0] SPEED_RPM,
    input  logic [15:0] FAN_RPM,
    input  logic        RPM_VALID,
    output logic [7:0]  FAN_DAC,
    output logic        AT_SPEED,
    output logic        STALL,
    output logic        WD_FAULT,
    output logic [1:0]  STATE
);

    localparam int unsigned PH_MAX =
        (SPINUP_CYC > STALL_HOLD) ? SPINUP_CYC : STALL_HOLD;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int WW = $clog2(WD_CYC + 1);
    localparam int SW = $clog2(STALL_SAMPLES + 1);

    fan_state_e    state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [7:0]    dac_q, dac_d;
    logic          at_q, at_d;
    logic          wdf_q, wdf_d;

    logic [7:0]    dac_step;
    logic          hold;

    fan_dac_step #(
        .DAC_MAX   (DAC_MAX),
        .DAC_MIN   (DAC_MIN),
        .DEADBAND  (DEADBAND),
        .BIG_ERR   (BIG_ERR),
        .STEP_FAST (STEP_FAST),
        .STEP_SLOW (STEP_SLOW)
    ) u_step (
        .dac_i  (dac_q),
        .neg_i  (FAN_RPM > SPEED_RPM),
        .mag_i  (rpm_mag(SPEED_RPM, FAN_RPM)),
        .dac_o  (dac_step),
        .hold_o (hold)
    );

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        wd_d    = wd_q + WW'(1);
        sc_d    = sc_q;
        dac_d   = dac_q;
        at_d    = at_q;
        wdf_d   = wdf_q;
        unique case (state_q)
            ST_SPINUP: begin
                dac_d = 8'(DAC_MAX);
                if (ph_q == PW'(SPINUP_CYC - 1)) begin
                    state_d = ST_TRACK;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            ST_TRACK: begin
                if (RPM_VALID) begin
                    if (FAN_RPM < 16'(STALL_RPM)) begin
                        if (sc_q != SW'(STALL_SAMPLES))
                            sc_d = sc_q + SW'(1);
                    end else begin
                        sc_d = '0;
                    end
                    // a stall overrides this sample's DAC step
                    if (sc_d == SW'(STALL_SAMPLES)) begin
                        state_d = ST_STALL;
                        ph_d    = '0;
                        dac_d   = 8'(DAC_MAX);
                        at_d    = 1'b0;
                    end else begin
                        dac_d = dac_step;
                        at_d  = hold;
                    end
                end
            end
            ST_STALL: begin
                dac_d = 8'(DAC_MAX);
                at_d  = 1'b0;
                if (ph_q == PW'(STALL_HOLD - 1)) begin
                    state_d = ST_SPINUP;
                    ph_d    = '0;
                    sc_d    = '0;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_SPINUP;
                ph_d    = '0;
                dac_d   = 8'(DAC_MAX);
            end
        endcase
        if (RPM_VALID) begin
            wd_d  = '0;
            wdf_d = 1'b0;
        end else if (wd_q == WW'(WD_CYC - 1)) begin
            wd_d    = '0;
            wdf_d   = 1'b1;
            dac_d   = 8'(DAC_MAX);
            state_d = ST_SPINUP;
            ph_d    = '0;
            sc_d    = '0;
            at_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK_400K or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_SPINUP;
            ph_q    <= '0;
            wd_q    <= '0;
            sc_q    <= '0;
            dac_q   <= 8'(DAC_MAX);
            at_q    <= 1'b0;
            wdf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            wd_q    <= wd_d;
            sc_q    <= sc_d;
            dac_q   <= dac_d;
            at_q    <= at_d;
            wdf_q   <= wdf_d;
        end
    end

    assign FAN_DAC  = dac_q;
    assign AT_SPEED = at_q;
    assign WD_FAULT = wdf_q;
    assign STATE    = state_q;
    assign STALL    = (state_q == ST_STALL);

endmodule

// File: tb/tb_fan_dac_loop.sv
// Bench for fan_dac_loop: directed scenarios plus random strobes,
// checked every cycle against a countdown-style behavioural model.
module tb_fan_dac_loop;

    logic        CLK_400K = 1'b0;
    logic        RESET    = 1'b0;
    logic [15:0] SPEED_RPM = '0;
    logic [15:0] FAN_RPM   = '0;
    logic        RPM_VALID = 1'b0;
    logic [7:0]  FAN_DAC;
    logic        AT_SPEED;
    logic        STALL;
    logic        WD_FAULT;
    logic [1:0]  STATE;

    fan_dac_loop #(
        .SPINUP_CYC (10),
        .STALL_HOLD (20),
        .WD_CYC     (50)
    ) dut (
        .CLK_400K  (CLK_400K),
        .RESET     (RESET),
        .SPEED_RPM (SPEED_RPM),
        .FAN_RPM   (FAN_RPM),
        .RPM_VALID (RPM_VALID),
        .FAN_DAC   (FAN_DAC),
        .AT_SPEED  (AT_SPEED),
        .STALL     (STALL),
        .WD_FAULT  (WD_FAULT),
        .STATE     (STATE)
    );

    always #5 CLK_400K = ~CLK_400K;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0/1/2, clocks left in the timed phase, clocks
    // since the last measurement, consecutive low samples.
    int m_st, m_left, m_quiet, m_low, m_dac;
    bit m_at, m_wdf;

    task automatic model_reset();
        m_st = 0; m_left = 10; m_quiet = 0; m_low = 0;
        m_dac = 255; m_at = 0; m_wdf = 0;
    endtask

    task automatic model_clock(input bit v, input int spd,
                               input int fan);
        int err, mag, stp;
        if (m_st == 0) begin
            m_dac = 255;
            m_left--;
            if (m_left == 0) m_st = 1;
        end else if (m_st == 1) begin
            if (v) begin
                m_low = (fan < 500) ? m_low + 1 : 0;
                if (m_low >= 3) begin
                    m_st = 2; m_left = 20; m_dac = 255; m_at = 0;
                end else begin
                    err = spd - fan;
                    mag = (err < 0) ? -err : err;
                    if (mag <= 100) begin
                        m_at = 1;
                    end else begin
                        m_at = 0;
                        stp = (mag > 1000) ? 8 : 1;
                        if (err > 0)
                            m_dac = (m_dac + stp > 255) ? 255 : m_dac + stp;
                        else
                            m_dac = (m_dac - stp < 40) ? 40 : m_dac - stp;
                    end
                end
            end
        end else begin
            m_dac = 255; m_at = 0;
            m_left--;
            if (m_left == 0) begin
                m_st = 0; m_left = 10; m_low = 0;
            end
        end
        if (v) begin
            m_quiet = 0; m_wdf = 0;
        end else begin
            m_quiet++;
            if (m_quiet == 50) begin
                m_quiet = 0; m_wdf = 1; m_dac = 255; m_at = 0;
                m_st = 0; m_left = 10; m_low = 0;
            end
        end
    endtask

    task automatic tick(input bit v, input int spd, input int fan);
        logic [12:0] exp;
        RPM_VALID = v;
        SPEED_RPM = 16'(spd);
        FAN_RPM   = 16'(fan);
        @(posedge CLK_400K);
        model_clock(v, spd, fan);
        #1;
        exp = {2'(m_st), m_st == 2, m_wdf, m_at, 8'(m_dac)};
        chk("cycle", 32'({STATE, STALL, WD_FAULT, AT_SPEED, FAN_DAC}),
            32'(exp));
        RPM_VALID = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        chk("rst_dac", 32'(FAN_DAC), 32'd255);
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_stall", 32'(STALL), 32'd0);
        chk("rst_wdf", 32'(WD_FAULT), 32'd0);
        chk("rst_at", 32'(AT_SPEED), 32'd0);
        @(posedge CLK_400K);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        int spd, fan;
        bit v;
        #3;
        do_reset();
        quiet(9);
        chk("spinup_hold", 32'(STATE), 32'd0);
        quiet(1);
        chk("spinup_done", 32'(STATE), 32'd1);

        tick(1, 3000, 5000);
        chk("fast_down", 32'(FAN_DAC), 32'd247);
        tick(1, 3000, 3500);
        chk("slow_down", 32'(FAN_DAC), 32'd246);
        tick(1, 3000, 3050);
        chk("dead_dac", 32'(FAN_DAC), 32'd246);
        chk("dead_at", 32'(AT_SPEED), 32'd1);

        for (int i = 0; i < 25; i++) tick(1, 3000, 5000);
        for (int i = 0; i < 2; i++) tick(1, 3000, 3500);
        chk("dac_44", 32'(FAN_DAC), 32'd44);
        for (int i = 0; i < 3; i++) begin
            tick(1, 3000, 5000);
            chk("floor", 32'(FAN_DAC), 32'd40);
        end

        for (int i = 0; i < 26; i++) tick(1, 5000, 3000);
        for (int i = 0; i < 2; i++) tick(1, 3500, 3000);
        chk("dac_250", 32'(FAN_DAC), 32'd250);
        for (int i = 0; i < 2; i++) begin
            tick(1, 5000, 3000);
            chk("ceil", 32'(FAN_DAC), 32'd255);
        end

        tick(1, 3000, 0);
        tick(1, 3000, 600);
        tick(1, 3000, 0);
        tick(1, 3000, 0);
        chk("no_stall", 32'(STATE), 32'd1);
        tick(1, 3000, 0);
        chk("stall_flag", 32'(STALL), 32'd1);
        chk("stall_dac", 32'(FAN_DAC), 32'd255);
        chk("stall_state", 32'(STATE), 32'd2);
        quiet(19);
        chk("stall_hold", 32'(STATE), 32'd2);
        quiet(1);
        chk("stall_exit", 32'(STATE), 32'd0);
        quiet(10);
        chk("respin", 32'(STATE), 32'd1);

        for (int i = 0; i < 21; i++) tick(1, 3000, 5000);
        for (int i = 0; i < 7; i++) tick(1, 3000, 3500);
        chk("dac_80", 32'(FAN_DAC), 32'd80);
        quiet(49);
        chk("wd_pre", 32'(WD_FAULT), 32'd0);
        quiet(1);
        chk("wd_fault", 32'(WD_FAULT), 32'd1);
        chk("wd_dac", 32'(FAN_DAC), 32'd255);
        chk("wd_state", 32'(STATE), 32'd0);
        tick(1, 3000, 3000);
        chk("wd_clear", 32'(WD_FAULT), 32'd0);
        quiet(9);
        chk("wd_respin", 32'(STATE), 32'd1);
        tick(1, 3000, 3000);
        quiet(49);
        tick(1, 3000, 3000);
        chk("wd_edge_f", 32'(WD_FAULT), 32'd0);
        chk("wd_edge_s", 32'(STATE), 32'd1);

        for (int i = 0; i < 19; i++) tick(1, 3000, 5000);
        for (int i = 0; i < 3; i++) tick(1, 3000, 3500);
        chk("dac_100", 32'(FAN_DAC), 32'd100);
        do_reset();
        quiet(9);
        chk("rst_spin", 32'(STATE), 32'd0);
        quiet(1);
        chk("rst_track", 32'(STATE), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                quiet(int'($urandom_range(40, 60)));
            end else if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                v   = ($urandom_range(0, 2) == 0);
                spd = int'($urandom_range(2500, 6500));
                if ($urandom_range(0, 9) < 2)
                    fan = int'($urandom_range(0, 700));
                else if ($urandom_range(0, 19) == 0)
                    fan = int'($urandom_range(0, 65535));
                else
                    fan = spd + int'($urandom_range(0, 3000)) - 1500;
                tick(v, spd, fan);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
